// File: rtl/patch_addr_pkg.sv
// Shared types and helpers for the patch address generator.
package patch_addr_pkg;

   localparam int unsigned MAX_PATCH_DEF  = 7;
   localparam int unsigned MAX_STRIDE_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   // Patch size must be odd (so also non-zero), fit the image and the
   // patch limit; stride must be non-zero and within the stride limit.
   function automatic logic cfg_legal(input logic [2:0] ps,
                                      input logic [2:0] st,
                                      input int unsigned max_patch,
                                      input int unsigned max_stride,
                                      input int unsigned min_dim);
      int unsigned p;
      int unsigned s;
      p = 32'(ps);
      s = 32'(st);
      return ps[0] && (p <= max_patch) && (p <= min_dim) &&
             (s != 0) && (s <= max_stride);
   endfunction

endpackage

// File: rtl/patch_addr_gen_therm_enc.sv
// Combinational binary-to-thermometer encoder: therm[i] = (i < val).
module therm_enc #(
   parameter int unsigned W  = 8,
   parameter int unsigned VW = 4
) (
   input  logic [VW-1:0] val,
   output logic [W-1:0]  therm
);

   // Set every bit whose index lies below the binary value.
   always_comb begin
      therm = '0;
      for (int unsigned i = 0; i < W; i++) begin
         therm[i] = (i < 32'(val));
      end
   end

endmodule

// File: rtl/patch_addr_gen.sv
// Patch address generator: walks convolution window positions row-major
// and emits thermometer x/y coordinates under valid/ready handshake.
// Optional macro PATCH_ADDR_GEN_ABORT_EN adds an abort input.
import patch_addr_pkg::*;

module patch_addr_gen #(
   parameter int unsigned IMG_W      = 28,
   parameter int unsigned IMG_H      = 28,
   parameter int unsigned MAX_PATCH  = MAX_PATCH_DEF,
   parameter int unsigned MAX_STRIDE = MAX_STRIDE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       patch_size,
   input  logic [2:0]       stride,
`ifdef PATCH_ADDR_GEN_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             patch_valid,
   input  logic             patch_ready,
   output logic [IMG_W-1:0] x_therm,
   output logic [IMG_H-1:0] y_therm,
   output logic             last,
   output logic             done,
   output logic             cfg_err
);

   localparam int unsigned MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
   localparam int unsigned MIND = (IMG_W < IMG_H) ? IMG_W : IMG_H;
   localparam int unsigned CW   = $clog2(MAXD) + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    x_q, x_d, y_q, y_d;
   logic [2:0]       ps_q, ps_d, st_q, st_d;
   logic             valid_q, valid_d;
   logic [IMG_W-1:0] xt_q, xt_d;
   logic [IMG_H-1:0] yt_q, yt_d;
   logic             last_q, last_d;
   logic             exh_q, exh_d;
   logic             cfg_err_q, cfg_err_d;

   logic [IMG_W-1:0] x_t;
   logic [IMG_H-1:0] y_t;
   logic [CW:0]      x_sum, y_sum, xl, yl;
   logic             last_now, load, abort_w;

`ifdef PATCH_ADDR_GEN_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   therm_enc #(.W(IMG_W), .VW(CW)) u_x_enc (.val(x_q), .therm(x_t));
   therm_enc #(.W(IMG_H), .VW(CW)) u_y_enc (.val(y_q), .therm(y_t));

   // Next-position arithmetic, one bit wider than the counters.
   always_comb begin
      xl       = (CW+1)'(IMG_W) - {{(CW-2){1'b0}}, ps_q};
      yl       = (CW+1)'(IMG_H) - {{(CW-2){1'b0}}, ps_q};
      x_sum    = {1'b0, x_q} + {{(CW-2){1'b0}}, st_q};
      y_sum    = {1'b0, y_q} + {{(CW-2){1'b0}}, st_q};
      last_now = (x_sum > xl) && (y_sum > yl);
      // exh_q blocks further loads once the final position is in the register.
      load     = !exh_q && (!valid_q || patch_ready);
   end

   // Next-state, counter and output-register logic.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      ps_d      = ps_q;
      st_d      = st_q;
      valid_d   = valid_q;
      xt_d      = xt_q;
      yt_d      = yt_q;
      last_d    = last_q;
      exh_d     = exh_q;
      cfg_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_legal(patch_size, stride, MAX_PATCH, MAX_STRIDE, MIND)) begin
                  ps_d    = patch_size;
                  st_d    = stride;
                  x_d     = '0;
                  y_d     = '0;
                  exh_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort_w) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (valid_q && patch_ready && last_q) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = ST_DONE;
            end else if (load) begin
               valid_d = 1'b1;
               xt_d    = x_t;
               yt_d    = y_t;
               last_d  = last_now;
               if (last_now) begin
                  exh_d = 1'b1;
               end else if (x_sum <= xl) begin
                  x_d = x_sum[CW-1:0];
               end else begin
                  x_d = '0;
                  y_d = y_sum[CW-1:0];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         ps_q      <= '0;
         st_q      <= '0;
         valid_q   <= 1'b0;
         xt_q      <= '0;
         yt_q      <= '0;
         last_q    <= 1'b0;
         exh_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         ps_q      <= ps_d;
         st_q      <= st_d;
         valid_q   <= valid_d;
         xt_q      <= xt_d;
         yt_q      <= yt_d;
         last_q    <= last_d;
         exh_q     <= exh_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign patch_valid = valid_q;
   assign x_therm     = xt_q;
   assign y_therm     = yt_q;
   assign last        = last_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: doc/patch_addr_gen.md
# patch_addr_gen

Runtime-configurable patch address generator for the convolutional clause datapath. For one image it walks every convolution window position in row-major order and emits thermometer-encoded x and y coordinates, one patch per valid/ready handshake. Patch size and stride are latched per image; image dimensions are parameters. It sits between the image buffer controller and the clause evaluation array. It replaces the fixed-case, cycle-count-driven y-only generator with incremental x/y counters, backpressure, explicit completion and configuration error reporting.

## Interface
- IMG_W, 28, image width in pixels; also the x thermometer width
- IMG_H, 28, image height in pixels; also the y thermometer width
- MAX_PATCH, 7, largest legal patch size (odd)
- MAX_STRIDE, 7, largest legal stride
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin an image; sampled only in IDLE
- patch_size  in  3  window side length; latched on accepted start
- stride  in  3  window step; latched on accepted start
- busy  out  1  high from accepted start until the done cycle, inclusive
- patch_valid  out  1  x_therm/y_therm hold a valid patch
- patch_ready  in  1  downstream accepts the patch
- x_therm  out  IMG_W  bit i = (i < x)
- y_therm  out  IMG_H  bit i = (i < y)
- last  out  1  qualifies the final patch of the image
- done  out  1  one-cycle pulse after the final handshake
- cfg_err  out  1  one-cycle pulse: start rejected

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 with a legal configuration latches patch_size/stride, clears x=y=0 and goes to RUN. An illegal configuration pulses cfg_err, stays in IDLE and emits no patch. Illegal means: patch_size even, 0, >MAX_PATCH or >min(IMG_W,IMG_H); stride 0 or >MAX_STRIDE.
- Limits: XL = IMG_W − patch_size, YL = IMG_H − patch_size.
- RUN: the output register loads when it is empty or patch_ready=1.
  - After each handshake: if x+stride ≤ XL, x += stride. Otherwise x = 0 and y += stride.
  - last = (x+stride > XL) && (y+stride > YL).
  - Handshake with last=1 → DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- No division or multiplication. Counter width is $clog2(max(IMG_W,IMG_H))+1; the sum x+stride is computed one bit wider.
- Outputs hold stable while patch_valid=1 and patch_ready=0.
- start during RUN or DONE is ignored. A latched configuration is never changed mid-image.
- patch_size == IMG dimension is legal: exactly one position on that axis.

## Timing
- Reset values: busy=0, patch_valid=0, x_therm=0, y_therm=0, last=0, done=0, cfg_err=0, state=IDLE.
- Reset mid-image aborts immediately. No done is produced.
- start accepted at edge N → busy and patch_valid high after edge N+1, with x=y=0.
- With patch_ready held high: one patch per cycle. Total cycles = positions + 1 (done).
- cfg_err rises one cycle after the rejected start.
- done rises one cycle after the last handshake. A new start is accepted in the cycle after done.

## Configuration
- PATCH_ADDR_GEN_ABORT_EN: adds input abort (1 bit).
  - abort=1 in RUN drops patch_valid next cycle and goes to IDLE without done.
  - abort in IDLE or DONE has no effect.
- Without the macro: no abort port; an image always completes or is reset.

## Structure
- Package patch_addr_pkg holds:
  - the state enum
  - the legality function for (patch_size, stride)
  - the MAX_PATCH and MAX_STRIDE defaults
- Sub-module therm_enc (parameter W): binary value → W-bit thermometer, combinational.
- Instantiate therm_enc twice (x, y) ahead of the output register.

## Test plan
- patch 3, stride 1, patch_ready=1 → 676 patches. The first has x_therm=y_therm=0. The last has 25 ones in each with last=1. done follows 1 cycle later.
- patch 5, stride 3 → x takes 0,3,…,21; 8×8=64 patches. The patch after x=21,y=0 has x=0,y=3.
- patch 7, stride 7, patch_ready toggled randomly → 16 patches, none dropped or duplicated. Outputs are stable while stalled.
- start with patch_size=4, then with stride=0 → a cfg_err pulse each time. patch_valid and busy stay 0.
- rst_n low at patch 100 of a 3/1 run → all outputs 0 immediately. A fresh start emits x=y=0 after edge N+1.
- With PATCH_ADDR_GEN_ABORT_EN: abort at patch 10 → patch_valid 0 next cycle, no done. A new start is accepted.
